// File: rtl/systolic_pkg.sv
// Shared types and index helpers for the systolic array result path.
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      STREAM
   } drain_state_e;

   // Flat position of element (r,c) in the column-major accumulator bus.
   function automatic int unsigned flat_idx(input int unsigned r,
                                            input int unsigned c,
                                            input int unsigned h);
      return r + c * h;
   endfunction

   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/systolic_idx_counter.sv
// Row-major 2-D (row, column) position counter with clear, increment and wrap.
module systolic_idx_counter
   import systolic_pkg::*;
#(
   parameter int unsigned height_p = 2,
   parameter int unsigned width_p  = 2
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          clear_i,
   input  logic                          incr_i,
   output logic [idx_w(height_p)-1:0]    row_o,
   output logic [idx_w(width_p)-1:0]     col_o,
   output logic [idx_w(height_p)-1:0]    row_nxt_o,
   output logic [idx_w(width_p)-1:0]     col_nxt_o,
   output logic                          last_o
);

   localparam int unsigned RW = idx_w(height_p);
   localparam int unsigned CW = idx_w(width_p);

   logic [RW-1:0] row_q, row_nxt;
   logic [CW-1:0] col_q, col_nxt;
   logic          row_last, col_last;

   assign row_last = (row_q == RW'(height_p - 1));
   assign col_last = (col_q == CW'(width_p - 1));

   always_comb begin
      row_nxt = row_q;
      col_nxt = col_q;
      if (col_last) begin
         col_nxt = '0;
         row_nxt = row_last ? '0 : row_q + 1'b1;
      end else begin
         col_nxt = col_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         row_q <= '0;
         col_q <= '0;
      end else if (clear_i) begin
         row_q <= '0;
         col_q <= '0;
      end else if (incr_i) begin
         row_q <= row_nxt;
         col_q <= col_nxt;
      end
   end

   assign row_o     = row_q;
   assign col_o     = col_q;
   assign row_nxt_o = row_nxt;
   assign col_nxt_o = col_nxt;
   assign last_o    = row_last && col_last;

endmodule

// File: rtl/systolic_drain.sv
// Result-side consumer for systolic_array: captures all accumulators at once,
// then streams them out row-major over valid/ready while the array runs again.
module systolic_drain
   import systolic_pkg::*;
#(
   parameter int unsigned width_p        = 32,
   parameter int unsigned array_width_p  = 2,
   parameter int unsigned array_height_p = 2
) (
   input  logic                                             clk_i,
   input  logic                                             reset_i,
   input  logic [width_p*array_width_p*array_height_p-1:0]  z_i,
   input  logic [array_width_p*array_height_p-1:0]          z_valid_i,
   output logic [array_width_p*array_height_p-1:0]          z_yumi_o,
   output logic [width_p-1:0]                               data_o,
   output logic                                             valid_o,
   input  logic                                             ready_i,
   output logic                                             last_o,
   output logic [idx_w(array_height_p)-1:0]                 row_idx_o,
   output logic [idx_w(array_width_p)-1:0]                  col_idx_o,
   output logic                                             busy_o,
   output logic [15:0]                                      frame_count_o
);

   localparam int unsigned N  = array_width_p * array_height_p;
   localparam int unsigned EW = idx_w(N);
   localparam int unsigned RW = idx_w(array_height_p);
   localparam int unsigned CW = idx_w(array_width_p);

   drain_state_e state_q, state_d;

   logic [width_p-1:0] z_word [N];
   logic [width_p-1:0] buf_q  [N];
   logic [width_p-1:0] data_q, data_d;
   logic [15:0]        fc_q;
   logic [RW-1:0]      row, row_nxt;
   logic [CW-1:0]      col, col_nxt;
   logic [EW-1:0]      nxt_sel;
   logic               cnt_last, capture, hs;

   for (genvar e = 0; e < N; e++) begin : g_unpack
      assign z_word[e] = z_i[e*width_p +: width_p];
   end

   assign capture = (state_q == CAPTURE);
   assign hs      = (state_q == STREAM) && ready_i;
   assign nxt_sel = EW'(flat_idx(row_nxt, col_nxt, array_height_p));

   systolic_idx_counter #(
      .height_p (array_height_p),
      .width_p  (array_width_p)
   ) u_idx (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .clear_i   (capture),
      .incr_i    (hs),
      .row_o     (row),
      .col_o     (col),
      .row_nxt_o (row_nxt),
      .col_nxt_o (col_nxt),
      .last_o    (cnt_last)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (&z_valid_i) state_d = CAPTURE;
         CAPTURE: state_d = STREAM;
         STREAM:  if (hs && cnt_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The output word is a register loaded one step ahead: element (0,0) straight
   // from the bus at capture, then the successor position on each handshake.
   always_comb begin
      data_d = data_q;
      unique case (state_q)
         IDLE:    data_d = '0;
         CAPTURE: data_d = z_word[0];
         STREAM:  if (hs) data_d = cnt_last ? '0 : buf_q[nxt_sel];
         default: data_d = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= IDLE;
         data_q  <= '0;
         fc_q    <= '0;
         buf_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         if (capture) buf_q <= z_word;
         if (hs && cnt_last) fc_q <= fc_q + 16'd1;
      end
   end

   assign z_yumi_o      = capture ? '1 : '0;
   assign valid_o       = (state_q == STREAM);
   assign data_o        = data_q;
   assign last_o        = valid_o && cnt_last;
   assign row_idx_o     = row;
   assign col_idx_o     = col;
   assign busy_o        = (state_q != IDLE);
   assign frame_count_o = fc_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain with a 2x2 array and 32-bit words.
module tb_systolic_drain;
   import systolic_pkg::*;

   localparam int unsigned WD = 32;
   localparam int unsigned AW = 2;
   localparam int unsigned AH = 2;
   localparam int unsigned N  = AW * AH;

   logic              clk_i = 1'b0;
   logic              reset_i;
   logic [WD*N-1:0]   z_i;
   logic [N-1:0]      z_valid_i;
   logic [N-1:0]      z_yumi_o;
   logic [WD-1:0]     data_o;
   logic              valid_o;
   logic              ready_i;
   logic              last_o;
   logic [0:0]        row_idx_o;
   logic [0:0]        col_idx_o;
   logic              busy_o;
   logic [15:0]       frame_count_o;

   int errors = 0;
   int checks = 0;

   // Row-major expected words for frame A (-2103, -3707, 21950, 30) and frame B.
   logic [31:0] fa [4] = '{32'hFFFFF7C9, 32'hFFFFF185, 32'h000055BE, 32'h0000001E};
   logic [31:0] fb [4] = '{32'h12345678, 32'hFFFFFFFF, 32'h80000000, 32'h00000007};

   systolic_drain #(
      .width_p        (WD),
      .array_width_p  (AW),
      .array_height_p (AH)
   ) dut (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .z_i           (z_i),
      .z_valid_i     (z_valid_i),
      .z_yumi_o      (z_yumi_o),
      .data_o        (data_o),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .last_o        (last_o),
      .row_idx_o     (row_idx_o),
      .col_idx_o     (col_idx_o),
      .busy_o        (busy_o),
      .frame_count_o (frame_count_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic load_frame(input logic [31:0] v00, input logic [31:0] v01,
                             input logic [31:0] v10, input logic [31:0] v11);
      z_i[WD*flat_idx(0, 0, AH) +: WD] = v00;
      z_i[WD*flat_idx(0, 1, AH) +: WD] = v01;
      z_i[WD*flat_idx(1, 0, AH) +: WD] = v10;
      z_i[WD*flat_idx(1, 1, AH) +: WD] = v11;
   endtask

   task automatic do_reset();
      reset_i   = 1'b0;
      z_valid_i = '0;
      ready_i   = 1'b0;
      @(posedge clk_i); #1;
      reset_i   = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] zero_vec;
      reset_i   = 1'b0;
      z_valid_i = '0;
      ready_i   = 1'b0;
      z_i       = '0;
      #12;
      checks++;
      if ({z_yumi_o, valid_o, data_o, last_o, row_idx_o, col_idx_o, busy_o, frame_count_o} !== '0) begin
         errors++;
         $display("FAIL reset_por: outputs=%h want 0", {z_yumi_o, valid_o, data_o, last_o, row_idx_o, col_idx_o, busy_o, frame_count_o});
      end
      @(posedge clk_i); #1;
      reset_i = 1'b1;
      load_frame(-2103, -3707, 21950, 30);
      z_valid_i = 4'b1111;
      @(posedge clk_i); #1;
      z_valid_i = '0;
      @(posedge clk_i); #1;
      ready_i = 1'b1;
      @(posedge clk_i); #1;
      checks++;
      if (valid_o !== 1'b1 || data_o !== fa[1]) begin
         errors++;
         $display("FAIL reset_pre_stream: valid=%b data=%h want 1 %h", valid_o, data_o, fa[1]);
      end
      #3 reset_i = 1'b0;
      #1;
      zero_vec = '0;
      checks++;
      if ({z_yumi_o, valid_o, data_o, last_o, row_idx_o, col_idx_o, busy_o} !== {4'b0, 1'b0, zero_vec, 4'b0}) begin
         errors++;
         $display("FAIL reset_mid_cycle: yumi=%b valid=%b data=%h last=%b row=%b col=%b busy=%b want all 0",
                  z_yumi_o, valid_o, data_o, last_o, row_idx_o, col_idx_o, busy_o);
      end
      checks++;
      if (frame_count_o !== 16'd0) begin
         errors++;
         $display("FAIL reset_frame_count: got %0d want 0", frame_count_o);
      end
      @(posedge clk_i); #1;
      reset_i = 1'b1;
      ready_i = 1'b0;
   endtask

   task automatic test_single_frame();
      logic [7:0] exp_flags;
      do_reset();
      load_frame(-2103, -3707, 21950, 30);
      z_valid_i = 4'b1111;
      ready_i   = 1'b1;
      @(posedge clk_i); #1;
      checks++;
      if ({z_yumi_o, valid_o, busy_o} !== {4'b1111, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL single_capture: yumi=%b valid=%b busy=%b want 1111 0 1", z_yumi_o, valid_o, busy_o);
      end
      z_valid_i = '0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk_i); #1;
         exp_flags = {1'b1, (k == 3), 1'(k / 2), 1'(k % 2), 4'b0000};
         checks++;
         if (data_o !== fa[k]) begin
            errors++;
            $display("FAIL single_data[%0d]: got %h want %h", k, data_o, fa[k]);
         end
         checks++;
         if ({valid_o, last_o, row_idx_o, col_idx_o, z_yumi_o} !== exp_flags) begin
            errors++;
            $display("FAIL single_flags[%0d]: valid/last/row/col/yumi=%b want %b", k,
                     {valid_o, last_o, row_idx_o, col_idx_o, z_yumi_o}, exp_flags);
         end
      end
      @(posedge clk_i); #1;
      checks++;
      if ({valid_o, last_o, busy_o, z_yumi_o} !== 7'b0 || data_o !== 32'h0) begin
         errors++;
         $display("FAIL single_idle: valid=%b last=%b busy=%b yumi=%b data=%h want all 0",
                  valid_o, last_o, busy_o, z_yumi_o, data_o);
      end
      checks++;
      if (frame_count_o !== 16'd1) begin
         errors++;
         $display("FAIL single_frame_count: got %0d want 1", frame_count_o);
      end
   endtask

   task automatic test_partial_valid();
      do_reset();
      load_frame(-2103, -3707, 21950, 30);
      z_valid_i = 4'b0111;
      ready_i   = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk_i); #1;
         checks++;
         if ({z_yumi_o, valid_o, busy_o} !== 6'b0) begin
            errors++;
            $display("FAIL partial_hold[%0d]: yumi=%b valid=%b busy=%b want 0", k, z_yumi_o, valid_o, busy_o);
         end
      end
      z_valid_i = 4'b1111;
      @(posedge clk_i); #1;
      checks++;
      if (z_yumi_o !== 4'b1111) begin
         errors++;
         $display("FAIL partial_yumi: got %b want 1111", z_yumi_o);
      end
      z_valid_i = '0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk_i); #1;
         checks++;
         if (valid_o !== 1'b1 || data_o !== fa[k]) begin
            errors++;
            $display("FAIL partial_data[%0d]: valid=%b data=%h want 1 %h", k, valid_o, data_o, fa[k]);
         end
      end
      @(posedge clk_i); #1;
      checks++;
      if (frame_count_o !== 16'd1) begin
         errors++;
         $display("FAIL partial_frame_count: got %0d want 1", frame_count_o);
      end
   endtask

   task automatic test_backpressure();
      int pat [7] = '{1, 0, 0, 1, 0, 1, 1};
      int exp_i = 0;
      int hs = 0;
      do_reset();
      load_frame(-2103, -3707, 21950, 30);
      z_valid_i = 4'b1111;
      ready_i   = 1'b0;
      @(posedge clk_i); #1;
      z_valid_i = '0;
      @(posedge clk_i); #1;
      for (int k = 0; k < 7; k++) begin
         ready_i = pat[k][0];
         checks++;
         if (valid_o !== 1'b1 || data_o !== fa[exp_i] ||
             row_idx_o !== 1'(exp_i / 2) || col_idx_o !== 1'(exp_i % 2) || last_o !== (exp_i == 3)) begin
            errors++;
            $display("FAIL bp_word[%0d]: valid=%b data=%h row=%b col=%b last=%b want 1 %h %0d %0d %0b",
                     k, valid_o, data_o, row_idx_o, col_idx_o, last_o, fa[exp_i], exp_i / 2, exp_i % 2, exp_i == 3);
         end
         if (valid_o && ready_i) hs++;
         @(posedge clk_i); #1;
         if (pat[k] != 0) exp_i++;
      end
      ready_i = 1'b0;
      checks++;
      if (hs != 4) begin
         errors++;
         $display("FAIL bp_handshakes: got %0d want 4", hs);
      end
      checks++;
      if (valid_o !== 1'b0 || frame_count_o !== 16'd1) begin
         errors++;
         $display("FAIL bp_end: valid=%b frame_count=%0d want 0 1", valid_o, frame_count_o);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      load_frame(-2103, -3707, 21950, 30);
      z_valid_i = 4'b1111;
      ready_i   = 1'b1;
      @(posedge clk_i); #1;
      checks++;
      if (z_yumi_o !== 4'b1111) begin
         errors++;
         $display("FAIL b2b_yumi_a: got %b want 1111", z_yumi_o);
      end
      for (int k = 0; k < 4; k++) begin
         @(posedge clk_i); #1;
         if (k == 0) load_frame(32'h12345678, 32'hFFFFFFFF, 32'h80000000, 32'h00000007);
         checks++;
         if (data_o !== fa[k] || z_yumi_o !== 4'b0000 || last_o !== (k == 3)) begin
            errors++;
            $display("FAIL b2b_frame_a[%0d]: data=%h yumi=%b last=%b want %h 0000 %0b",
                     k, data_o, z_yumi_o, last_o, fa[k], k == 3);
         end
      end
      @(posedge clk_i); #1;
      checks++;
      if ({z_yumi_o, valid_o, busy_o} !== 6'b0) begin
         errors++;
         $display("FAIL b2b_idle_gap: yumi=%b valid=%b busy=%b want 0", z_yumi_o, valid_o, busy_o);
      end
      @(posedge clk_i); #1;
      checks++;
      if (z_yumi_o !== 4'b1111) begin
         errors++;
         $display("FAIL b2b_yumi_b: got %b want 1111", z_yumi_o);
      end
      z_valid_i = '0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk_i); #1;
         checks++;
         if (valid_o !== 1'b1 || data_o !== fb[k] || last_o !== (k == 3)) begin
            errors++;
            $display("FAIL b2b_frame_b[%0d]: valid=%b data=%h last=%b want 1 %h %0b",
                     k, valid_o, data_o, last_o, fb[k], k == 3);
         end
      end
      @(posedge clk_i); #1;
      checks++;
      if (frame_count_o !== 16'd2) begin
         errors++;
         $display("FAIL b2b_frame_count: got %0d want 2", frame_count_o);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      load_frame(-2103, -3707, 21950, 30);
      z_valid_i = 4'b1111;
      ready_i   = 1'b1;
      @(posedge clk_i); #1;
      z_valid_i = '0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk_i); #1;
         checks++;
         if (data_o !== fa[k] || last_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pre[%0d]: data=%h last=%b want %h 0", k, data_o, last_o, fa[k]);
         end
      end
      reset_i = 1'b0;
      #1;
      checks++;
      if ({valid_o, last_o, busy_o, z_yumi_o, row_idx_o, col_idx_o} !== 9'b0 || data_o !== 32'h0 ||
          frame_count_o !== 16'd0) begin
         errors++;
         $display("FAIL midrst_clear: valid=%b last=%b busy=%b data=%h fc=%0d want all 0",
                  valid_o, last_o, busy_o, data_o, frame_count_o);
      end
      @(posedge clk_i); #1;
      reset_i = 1'b1;
      load_frame(32'h12345678, 32'hFFFFFFFF, 32'h80000000, 32'h00000007);
      z_valid_i = 4'b1111;
      @(posedge clk_i); #1;
      z_valid_i = '0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk_i); #1;
         checks++;
         if (valid_o !== 1'b1 || data_o !== fb[k] || row_idx_o !== 1'(k / 2) ||
             col_idx_o !== 1'(k % 2) || last_o !== (k == 3)) begin
            errors++;
            $display("FAIL midrst_new[%0d]: valid=%b data=%h row=%b col=%b last=%b want 1 %h %0d %0d %0b",
                     k, valid_o, data_o, row_idx_o, col_idx_o, last_o, fb[k], k / 2, k % 2, k == 3);
         end
      end
      @(posedge clk_i); #1;
      checks++;
      if (frame_count_o !== 16'd1) begin
         errors++;
         $display("FAIL midrst_frame_count: got %0d want 1", frame_count_o);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_partial_valid();
      test_backpressure();
      test_back_to_back();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
